// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C write engine: FSM states, frame size and
// the quarter-bit divider derivation.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_ACK,
        ST_STOP,
        ST_DONE
    } i2cState_t;

    localparam int NUM_BYTES = 3;
    localparam int WORD_W    = 8 * NUM_BYTES;

    // Four quarter-bit ticks make one SCL period; never let the divider reach zero.
    function automatic int calcQtr(input int clkFreq, input int i2cFreq);
        int qtr;
        qtr = clkFreq / (4 * i2cFreq);
        return (qtr < 1) ? 1 : qtr;
    endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Free-running quarter-bit divider; iCLR restarts the count so the first
// tick of a transfer lands exactly QTR cycles after acceptance.
module i2c_tick_gen #(
    parameter int QTR = 625
) (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic iCLR,
    output logic oTICK
);

    localparam int            CW   = (QTR > 1) ? $clog2(QTR) : 1;
    localparam logic [CW-1:0] LAST = CW'(QTR - 1);

    logic [CW-1:0] count;

    always_ff @(posedge iCLK) begin
        if (!iRST_N || iCLR) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign oTICK = (count == LAST) && !iCLR;

endmodule

// File: rtl/i2c_write_engine.sv
// Three-byte I2C master write: START, 24 data bits with slave ACK slots,
// STOP. Every slot is four quarter-bit ticks; SCL/SDA are registered.
module i2c_write_engine
    import i2c_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int I2C_FREQ = 20000
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic [WORD_W-1:0] iDATA,
    input  logic              iGO,
    output logic              oEND,
    output logic              oACK,
    output logic              oBUSY,
    output logic              I2C_SCLK,
    inout  wire logic         I2C_SDAT
);

    localparam int         QTR       = calcQtr(CLK_FREQ, I2C_FREQ);
    localparam logic [1:0] LAST_BYTE = 2'(NUM_BYTES - 1);

    i2cState_t         state, stateNext;
    logic [1:0]        phase, phaseNext;
    logic [2:0]        bitCnt, bitCntNext;
    logic [1:0]        byteCnt, byteCntNext;
    logic [WORD_W-1:0] shiftReg, shiftNext;
    logic              nackFlag, nackNext;
    logic              endNext, ackNext, busyNext;
    logic              sclNext, sdaRelNext, sdaRel;
    logic              tick, accept;
    logic [1:0]        sdaSync;

    i2c_tick_gen #(
        .QTR (QTR)
    ) uTickGen (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .iCLR   (accept),
        .oTICK  (tick)
    );

    // Returns {scl, sdaRelease} for a given slot and phase.
    function automatic logic [1:0] busLevels(input i2cState_t st,
                                             input logic [1:0] ph,
                                             input logic dataBit);
        case (st)
            ST_START: return {ph != 2'd3, ph == 2'd0};
            ST_BIT:   return {(ph == 2'd1) || (ph == 2'd2), dataBit};
            ST_ACK:   return {(ph == 2'd1) || (ph == 2'd2), 1'b1};
            ST_STOP:  return {ph != 2'd0, ph[1]};
            default:  return 2'b11;
        endcase
    endfunction

    // Two-flop synchroniser for the slave's acknowledge level.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            sdaSync <= 2'b11;
        end else begin
            sdaSync <= {sdaSync[0], I2C_SDAT};
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state    <= ST_IDLE;
            phase    <= 2'd0;
            bitCnt   <= 3'd0;
            byteCnt  <= 2'd0;
            nackFlag <= 1'b0;
            oEND     <= 1'b0;
            oACK     <= 1'b0;
            oBUSY    <= 1'b0;
            I2C_SCLK <= 1'b1;
            sdaRel   <= 1'b1;
        end else begin
            state    <= stateNext;
            phase    <= phaseNext;
            bitCnt   <= bitCntNext;
            byteCnt  <= byteCntNext;
            nackFlag <= nackNext;
            oEND     <= endNext;
            oACK     <= ackNext;
            oBUSY    <= busyNext;
            I2C_SCLK <= sclNext;
            sdaRel   <= sdaRelNext;
        end
    end

    always_ff @(posedge iCLK) begin
        shiftReg <= shiftNext;
    end

    always_comb begin
        stateNext   = state;
        phaseNext   = phase;
        bitCntNext  = bitCnt;
        byteCntNext = byteCnt;
        shiftNext   = shiftReg;
        nackNext    = nackFlag;
        endNext     = oEND;
        ackNext     = oACK;
        busyNext    = oBUSY;
        accept      = 1'b0;

        unique case (state)
            ST_IDLE: begin
                endNext  = 1'b0;
                busyNext = 1'b0;
                if (iGO && !oEND) begin
                    accept      = 1'b1;
                    shiftNext   = iDATA;
                    nackNext    = 1'b0;
                    busyNext    = 1'b1;
                    stateNext   = ST_START;
                    phaseNext   = 2'd0;
                    bitCntNext  = 3'd7;
                    byteCntNext = 2'd0;
                end
            end
            ST_START: begin
                if (tick) begin
                    phaseNext = phase + 2'd1;
                    if (phase == 2'd3) stateNext = ST_BIT;
                end
            end
            ST_BIT: begin
                if (tick) begin
                    phaseNext = phase + 2'd1;
                    if (phase == 2'd3) begin
                        shiftNext = {shiftReg[WORD_W-2:0], 1'b0};
                        if (bitCnt == 3'd0) stateNext = ST_ACK;
                        else bitCntNext = bitCnt - 3'd1;
                    end
                end
            end
            ST_ACK: begin
                if (tick) begin
                    phaseNext = phase + 2'd1;
                    // A released (high) line at mid-SCL-high means NACK; keep going regardless.
                    if (phase == 2'd2 && sdaSync[1]) nackNext = 1'b1;
                    if (phase == 2'd3) begin
                        bitCntNext = 3'd7;
                        if (byteCnt == LAST_BYTE) begin
                            stateNext = ST_STOP;
                        end else begin
                            byteCntNext = byteCnt + 2'd1;
                            stateNext   = ST_BIT;
                        end
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    phaseNext = phase + 2'd1;
                    if (phase == 2'd3) begin
                        stateNext = ST_DONE;
                        busyNext  = 1'b0;
                        endNext   = 1'b1;
                        ackNext   = nackFlag;
                    end
                end
            end
            ST_DONE: begin
                endNext  = 1'b1;
                busyNext = 1'b0;
                if (!iGO) begin
                    endNext   = 1'b0;
                    stateNext = ST_IDLE;
                end
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase

        {sclNext, sdaRelNext} = busLevels(stateNext, phaseNext, shiftNext[WORD_W-1]);
    end

    assign I2C_SDAT = sdaRel ? 1'bz : 1'b0;

endmodule

// File: tb/tb_i2c_write_engine.sv
// Bench for i2c_write_engine: slave model, bus decoder and scoreboard
// comparing decoded frames and completion status against expected transfers.
module tb_i2c_write_engine;

    localparam int CLK_FREQ = 400;
    localparam int I2C_FREQ = 10;
    localparam int QTR      = CLK_FREQ / (4 * I2C_FREQ);
    localparam int NBYTES   = 3;
    localparam int XFER_CYC = (1 + 9 * NBYTES + 1) * 4 * QTR;

    typedef struct {
        logic [23:0] word;
        logic [2:0]  nackMask;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic        go;
    logic [23:0] data;
    logic        oEND, oACK, oBUSY, scl;
    wire         sdaBus;
    logic        slaveDrive = 1'b0;
    logic [2:0]  nackMask = 3'b000;

    exp_t expQ[$];
    exp_t eItem;
    int   nChecks = 0;
    int   nFail = 0;
    int   cyc = 0;
    int   acceptCyc = 0;
    int   startCount = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign sdaBus = slaveDrive ? 1'b0 : 1'bz;
    pullup (sdaBus);

    i2c_write_engine #(
        .CLK_FREQ (CLK_FREQ),
        .I2C_FREQ (I2C_FREQ)
    ) dut (
        .iCLK     (clk),
        .iRST_N   (rstN),
        .iDATA    (data),
        .iGO      (go),
        .oEND     (oEND),
        .oACK     (oACK),
        .oBUSY    (oBUSY),
        .I2C_SCLK (scl),
        .I2C_SDAT (sdaBus)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic failNow(input string name, input string detail);
        nChecks++;
        nFail++;
        $display("FAIL %s: %s (cycle %0d)", name, detail, cyc);
    endtask

    // Slave: ACKs (pulls low) after each byte's 8th SCL fall unless masked as NACK.
    int   sFalls = 100;
    logic sPrevScl = 1'b1, sPrevSda = 1'b1;
    always @(negedge clk) begin
        if (slaveDrive) check("sda_contention", {31'd0, sdaBus}, 32'd0);
        if (!rstN) begin
            slaveDrive <= 1'b0;
            sFalls = 100;
        end else if (sPrevScl && scl && sPrevSda && !sdaBus) begin
            sFalls = -1;
        end else if (sPrevScl && !scl) begin
            sFalls++;
            if (sFalls >= 1 && sFalls <= 9 * NBYTES) begin
                if ((sFalls - 1) % 9 == 7) slaveDrive <= !nackMask[(sFalls - 1) / 9];
                if ((sFalls - 1) % 9 == 8) slaveDrive <= 1'b0;
            end
        end
        sPrevScl = scl;
        sPrevSda = sdaBus;
    end

    // Bus decoder: START/STOP framing, bits on SCL rise, any other SDA move under SCL high is an error.
    logic        mPrevScl = 1'b1, mPrevSda = 1'b1;
    bit          inFrame = 1'b0;
    int          bitIdx = 0;
    logic [26:0] frameBits = '0;
    always @(negedge clk) begin
        if (!rstN) begin
            inFrame = 1'b0;
            bitIdx  = 0;
        end else begin
            if (mPrevScl && scl && sdaBus !== mPrevSda) begin
                if (!sdaBus && !inFrame) begin
                    inFrame = 1'b1;
                    bitIdx  = 0;
                    startCount++;
                end else if (sdaBus && inFrame && bitIdx == 9 * NBYTES + 1) begin
                    inFrame = 1'b0;
                    if (expQ.size() == 0) begin
                        failNow("frame_unexpected", "STOP seen with no transfer outstanding");
                    end else begin
                        check("frame_word", {8'd0, frameBits[26:19], frameBits[17:10], frameBits[8:1]},
                              {8'd0, expQ[0].word});
                        check("frame_acks", {29'd0, frameBits[0], frameBits[9], frameBits[18]},
                              {29'd0, expQ[0].nackMask});
                    end
                end else begin
                    failNow("bus_glitch", $sformatf("SDA went to %0b while SCL high, frame bit %0d, required stable",
                                                    sdaBus, bitIdx));
                end
            end
            if (!mPrevScl && scl && inFrame) begin
                if (bitIdx < 9 * NBYTES) frameBits[26 - bitIdx] = sdaBus;
                bitIdx++;
            end
        end
        mPrevScl = scl;
        mPrevSda = sdaBus;
    end

    // Completion checker: pops one expected transfer per rising oEND.
    logic ePrevEnd = 1'b0;
    always @(negedge clk) begin
        if (rstN && oEND && !ePrevEnd) begin
            if (expQ.size() == 0) begin
                failNow("end_unexpected", "oEND rose with no transfer outstanding");
            end else begin
                eItem = expQ.pop_front();
                check("oACK", {31'd0, oACK}, {31'd0, |eItem.nackMask});
                check("latency", cyc - acceptCyc, XFER_CYC);
                check("oBUSY_at_end", {31'd0, oBUSY}, 32'd0);
            end
        end
        ePrevEnd = oEND;
    end

    task automatic doXfer(input logic [23:0] w, input logic [2:0] m, input int dropAt,
                          input int changeAt, input int holdAfter);
        int k;
        int startsBefore;
        bit got;
        nackMask     = m;
        startsBefore = startCount;
        @(posedge clk);
        #1;
        data      = w;
        go        = 1'b1;
        acceptCyc = cyc + 1;
        expQ.push_back('{w, m});
        k   = 0;
        got = 1'b0;
        while (k < XFER_CYC + 100 && !got) begin
            @(posedge clk);
            #1;
            k++;
            if (k == dropAt) go = 1'b0;
            if (k == changeAt) data = 24'($urandom);
            if (k == 5) check("oBUSY_mid", {31'd0, oBUSY}, 32'd1);
            if (oEND) got = 1'b1;
        end
        if (!got) failNow("oEND_timeout", $sformatf("no oEND within %0d cycles", XFER_CYC + 100));
        if (dropAt >= 0) begin
            @(posedge clk);
            #1;
            check("oEND_pulse", {31'd0, oEND}, 32'd0);
        end else begin
            repeat (holdAfter) @(posedge clk);
            #1;
            check("oEND_held", {31'd0, oEND}, 32'd1);
            check("no_restart", {31'd0, oBUSY}, 32'd0);
            go = 1'b0;
            @(posedge clk);
            #1;
            check("oEND_fall", {31'd0, oEND}, 32'd0);
        end
        check("one_transfer", startCount - startsBefore, 32'd1);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dropAt;
        rstN = 1'b0;
        go   = 1'b0;
        data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_scl", {31'd0, scl}, 32'd1);
        check("rst_sda", {31'd0, sdaBus}, 32'd1);
        check("rst_oEND", {31'd0, oEND}, 32'd0);
        check("rst_oACK", {31'd0, oACK}, 32'd0);
        check("rst_oBUSY", {31'd0, oBUSY}, 32'd0);
        rstN = 1'b1;
        repeat (2) @(posedge clk);

        doXfer(24'h34001A, 3'b000, -1, -1, 3);
        doXfer(24'h400457, 3'b100, -1, -1, 3);
        repeat (10) @(posedge clk);
        #1;
        check("oACK_hold", {31'd0, oACK}, 32'd1);

        doXfer(24'($urandom), 3'b000, -1, -1, 5000 - XFER_CYC - 1);

        // Reset in the middle of byte 1.
        nackMask = 3'b000;
        @(posedge clk);
        #1;
        data = 24'hA5C3F0;
        go   = 1'b1;
        repeat (40 * QTR) @(posedge clk);
        #1;
        rstN = 1'b0;
        go   = 1'b0;
        @(posedge clk);
        #1;
        check("abort_scl", {31'd0, scl}, 32'd1);
        check("abort_sda", {31'd0, sdaBus}, 32'd1);
        check("abort_oBUSY", {31'd0, oBUSY}, 32'd0);
        check("abort_oACK", {31'd0, oACK}, 32'd0);
        expQ.delete();
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
        repeat (2) @(posedge clk);
        doXfer(24'hA5C3F0, 3'b010, -1, -1, 2);

        doXfer(24'h5AA5C3, 3'b000, 50 * QTR, 60 * QTR, 0);

        for (int i = 0; i < 4; i++) begin
            dropAt = ($urandom_range(0, 1) == 1) ? int'($urandom_range(10, XFER_CYC - 10)) : -1;
            doXfer(24'($urandom), 3'($urandom_range(0, 7)), dropAt,
                   (dropAt >= 0) ? dropAt + 7 : 300, int'($urandom_range(0, 20)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/i2c_write_engine.md
I2C_WRITE_ENGINE -- requirements
Module: i2c_write_engine

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter I2C_FREQ, default 20000, SCL bit rate in Hz.
REQ-003 iCLK  input  1  system clock; one clock only, all logic on its rising edge.
REQ-004 iRST_N  input  1  reset, synchronous and active-low.
REQ-005 iDATA  input  24  transfer word {slave_addr+W, sub_addr, data}, sent MSB first.
REQ-006 iGO  input  1  level request; high = perform one transfer.
REQ-007 oEND  output  1  transfer complete.
REQ-008 oACK  output  1  1 = at least one NACK seen in the last transfer; 0 = all three bytes acknowledged.
REQ-009 oBUSY  output  1  high from transfer acceptance until STOP completes.
REQ-010 I2C_SCLK  output  1  I2C clock, push-pull.
REQ-011 I2C_SDAT  inout  1  I2C data, open-drain: drives 0 or high-Z only, never 1.

Function
REQ-012 Quarter-bit tick every QTR = CLK_FREQ/(4*I2C_FREQ) iCLK cycles (625 at defaults); divider cleared on transfer acceptance.
REQ-013 States: IDLE, START, BIT, ACK, STOP, DONE; each START/BIT/ACK/STOP slot lasts exactly 4 ticks (phases 0-3).
REQ-014 IDLE: SCLK=1, SDAT released; when iGO=1 and oEND=0, latch iDATA, clear NACK flag, assert oBUSY, enter START next cycle.
REQ-015 START: SDAT driven low at phase 1 with SCLK high; SCLK low at phase 3.
REQ-016 BIT: SCLK low in phases 0 and 3, high in phases 1 and 2; SDAT set at phase 0 from the current latched bit (0 = drive low, 1 = release).
REQ-017 Bit counter 7 down to 0 per byte; after bit 0 enter ACK; byte counter 0..2.
REQ-018 ACK: SDAT released; SDAT sampled at phase 2; sampled 1 sets NACK flag; then next byte's BIT, or STOP after byte 2.
REQ-019 A NACK does not abort; all 3 bytes and STOP are always sent.
REQ-020 STOP: SDAT low at phase 0, SCLK high at phase 1, SDAT released at phase 2 (SCLK high).
REQ-021 Total transfer = 116 ticks (1 + 27 + 1 slots x 4) = 72500 cycles at defaults, from acceptance to DONE.
REQ-022 DONE: oBUSY=0, oACK=NACK flag, oEND=1; oEND held while iGO=1; when iGO=0, oEND falls and state returns to IDLE on the next cycle.
REQ-023 iGO falling mid-transfer is ignored; the transfer completes, DONE pulses oEND for one cycle, then IDLE.
REQ-024 iGO held high after DONE does not start a new transfer; a new transfer requires iGO low for at least one cycle, then high.
REQ-025 iDATA changes after acceptance have no effect on the current transfer.
REQ-026 oACK holds its value until the next acceptance.

Reset
REQ-027 While iRST_N=0 at a clock edge: state IDLE, SCLK=1, SDAT released, oEND=0, oACK=0, oBUSY=0, all counters and divider 0.
REQ-028 Reset mid-transfer abandons the transfer with no STOP generated; the bus is released within one cycle.

Structure
REQ-029 Shared package i2c_pkg holds the state enumeration, the byte count (3), and the QTR derivation.
REQ-030 One sub-module, i2c_tick_gen, is natural: parameterised divider with a clear input and a one-cycle tick output.

Verification
REQ-031 CLK_FREQ=400, I2C_FREQ=10 (QTR=10), slave ACKs all bytes, iDATA=0x34001A -> bytes 0x34, 0x00, 0x1A observed MSB-first between START and STOP; oEND after 1160 cycles; oACK=0.
REQ-032 Slave NACKs byte 2 of iDATA=0x400457 -> all 3 bytes and STOP are still sent; oEND=1 and oACK=1.
REQ-033 iGO held high for 5000 cycles -> exactly one transfer; oEND stays 1 until iGO drops, then oEND=0 on the next cycle.
REQ-034 iRST_N low at tick 40 -> next cycle SCLK=1, SDAT=Z, oBUSY=0; a new iGO runs a clean full transfer.
REQ-035 iGO dropped at tick 50 and iDATA changed at tick 60 -> the original word completes; oEND is a single-cycle pulse.
REQ-036 A bus monitor over all tests flags any SDAT change while SCLK=1 other than START and STOP, and any cycle where SDAT is driven high.
